// File: rtl/agu_rd_port.sv
// Read-side responder for the AGU: request stream -> synchronous word memory
// lookup -> 2-entry output buffer with credit-based request flow control.
module agu_rd_port #(
  parameter int W     = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 256,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          req_valid,
  input  logic [AW-1:0] req_addr,
  input  logic          req_last,
  output logic          req_ready,
  output logic          rd_valid,
  output logic [W-1:0]  rd_data,
  output logic          rd_last,
  input  logic          rd_ready,
  input  logic          clr,
  output logic          err
);

  logic [W-1:0] mem [DEPTH];

  logic          acc;
  logic          oor;
  logic          push;
  logic          pop;
  logic [1:0]    occ;

  logic          s1_valid;
  logic          s1_last;
  logic [W-1:0]  s1_data;

  logic [W-1:0]  fifo_data [2];
  logic [1:0]    fifo_last;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;

  // DEPTH is a power of two, so any set bit above the index field is out of range
  assign oor  = |req_addr[AW-1:IW];
  assign push = s1_valid;
  assign pop  = rd_valid & rd_ready;
  assign occ  = count + {1'b0, s1_valid};

  assign req_ready = (occ < 2'd2) | pop;
  assign acc       = req_valid & req_ready;

  assign rd_valid = (count != 2'd0);
  assign rd_data  = fifo_data[rd_ptr];
  assign rd_last  = fifo_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-first: the non-blocking write above lands after this read samples mem
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= acc;
      if (acc) begin
        s1_data <= oor ? '0 : mem[req_addr[IW-1:0]];
        s1_last <= req_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (acc && oor) begin
      err <= 1'b1;
    end else if (clr) begin
      err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= s1_data;
        fifo_last[wr_ptr] <= s1_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
